// File: rtl/block_packer_pkg.sv
// Shared widths, lane/block types and the lane-merge helper for the block packer.
// A block is a packed array of lanes, so lane i sits at [i*DATA_WIDTH +: DATA_WIDTH].
package block_packer_pkg;

    localparam int DATA_WIDTH    = 32;
    localparam int NUM_DATA      = 8;
    localparam int IDX_WIDTH     = $clog2(NUM_DATA);
    localparam int BLK_CNT_WIDTH = 16;
    localparam int BLOCK_WIDTH   = DATA_WIDTH * NUM_DATA;

    typedef logic [DATA_WIDTH-1:0]    word_t;
    typedef word_t [NUM_DATA-1:0]     block_t;
    typedef logic [IDX_WIDTH-1:0]     idx_t;
    typedef logic [BLK_CNT_WIDTH-1:0] blk_cnt_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_DATA - 1);

    // Keeps lanes below idx, writes word into lane idx, forces every higher lane to zero.
    function automatic block_t merge_lane(block_t acc, idx_t idx, word_t word);
        block_t blk;
        for (int i = 0; i < NUM_DATA; i++) begin
            if (i < int'(idx)) begin
                blk[i] = acc[i];
            end else if (i == int'(idx)) begin
                blk[i] = word;
            end else begin
                blk[i] = '0;
            end
        end
        return blk;
    endfunction

endpackage

// File: rtl/block_packer_if.sv
// Word-stream input and block-push output of the block packer.
// The master side drives words and the FIFO-full status; the slave side is the packer.
interface block_packer_if;
    import block_packer_pkg::*;

    logic   in_valid;
    word_t  in_data;
    logic   in_last;
    logic   in_ready;
    logic   fifo_full;
    logic   push_infifo;
    block_t data_out;

    modport master (
        output in_valid, in_data, in_last, fifo_full,
        input  in_ready, push_infifo, data_out
    );

    modport slave (
        input  in_valid, in_data, in_last, fifo_full,
        output in_ready, push_infifo, data_out
    );

endinterface

// File: rtl/block_packer_register.sv
// Generic enabled register with asynchronous active-high clear.
module block_packer_register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load d when enabled, otherwise hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/block_packer.sv
// Packs a 32-bit word stream into NUM_DATA-lane blocks through an accumulator and a
// single hold register; a finished block waits in the accumulator (acc_done) if hold is busy.
module block_packer
    import block_packer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             wrt_en,
    block_packer_if.slave    bus,
    output blk_cnt_t         blk_count,
    output logic             busy
);

    block_t   acc_q, acc_d;
    idx_t     idx_q, idx_d;
    logic     acc_done_q, acc_done_d;
    blk_cnt_t blk_count_q, blk_count_d;
    block_t   hold_q, hold_d;
    logic     hold_valid_q, hold_valid_d;

    logic     in_ready_s;
    logic     accept_s;
    logic     complete_s;
    logic     push_s;
    logic     hold_free_s;
    logic     hold_load_s;
    block_t   merged_s;

    // Handshakes, block completion and next-state for accumulator, hold and counter.
    always_comb begin
        push_s      = wrt_en & hold_valid_q & ~bus.fifo_full;
        in_ready_s  = wrt_en & ~acc_done_q & ~reset;
        accept_s    = bus.in_valid & in_ready_s;
        complete_s  = accept_s & ((idx_q == LAST_IDX) | bus.in_last);
        hold_free_s = ~hold_valid_q | push_s;
        merged_s    = merge_lane(acc_q, idx_q, bus.in_data);

        acc_d       = acc_q;
        idx_d       = idx_q;
        acc_done_d  = acc_done_q;
        hold_d      = hold_q;
        hold_load_s = 1'b0;

        if (wrt_en) begin
            if (acc_done_q) begin
                if (hold_free_s) begin
                    hold_d      = acc_q;
                    hold_load_s = 1'b1;
                    acc_d       = '0;
                    idx_d       = '0;
                    acc_done_d  = 1'b0;
                end else begin
                    acc_done_d  = 1'b1;
                end
            end else if (complete_s) begin
                if (hold_free_s) begin
                    hold_d      = merged_s;
                    hold_load_s = 1'b1;
                    acc_d       = '0;
                    idx_d       = '0;
                end else begin
                    // Park the finished block in acc; in_ready drops until hold frees up.
                    acc_d       = merged_s;
                    idx_d       = '0;
                    acc_done_d  = 1'b1;
                end
            end else if (accept_s) begin
                acc_d = merged_s;
                idx_d = idx_q + idx_t'(1);
            end else begin
                acc_d = acc_q;
            end
        end else begin
            hold_load_s = 1'b0;
        end

        if (hold_load_s) begin
            hold_valid_d = 1'b1;
        end else if (push_s) begin
            hold_valid_d = 1'b0;
        end else begin
            hold_valid_d = hold_valid_q;
        end

        if (push_s) begin
            blk_count_d = blk_count_q + blk_cnt_t'(1);
        end else begin
            blk_count_d = blk_count_q;
        end
    end

    // Accumulator, lane index, parked-block flag and emitted-block counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= '0;
            idx_q       <= '0;
            acc_done_q  <= 1'b0;
            blk_count_q <= '0;
        end else begin
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            acc_done_q  <= acc_done_d;
            blk_count_q <= blk_count_d;
        end
    end

    block_packer_register #(.WIDTH(BLOCK_WIDTH)) u_hold (
        .clk (clk),
        .rst (reset),
        .en  (hold_load_s),
        .d   (hold_d),
        .q   (hold_q)
    );

    block_packer_register #(.WIDTH(1)) u_hold_valid (
        .clk (clk),
        .rst (reset),
        .en  (1'b1),
        .d   (hold_valid_d),
        .q   (hold_valid_q)
    );

    assign bus.in_ready    = in_ready_s;
    assign bus.push_infifo = push_s;
    assign bus.data_out    = hold_q;
    assign blk_count       = blk_count_q;
    assign busy            = (idx_q != idx_t'(0)) | acc_done_q | hold_valid_q;

endmodule
